// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: glyph table, sequence-tracker states and
// the pattern-to-digit decode function used by both decoder and display driver.
package seg7_pkg;

  typedef enum logic {
    HUNT  = 1'b0,
    TRACK = 1'b1
  } seq_state_t;

  typedef struct packed {
    logic       illegal;
    logic [3:0] digit;
  } seg7_dec_t;

  // Index is the hex digit; bit 6 = segment a ... bit 0 = segment g.
  localparam logic [6:0] GLYPH_TABLE [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h73, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  // Any pattern not found in the glyph table is flagged illegal with digit 0.
  function automatic seg7_dec_t seg7_decode_pattern(input logic [6:0] pattern);
    seg7_dec_t result;
    result.illegal = 1'b1;
    result.digit   = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == GLYPH_TABLE[i]) begin
        result.illegal = 1'b0;
        result.digit   = 4'(i);
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment pattern decoder: pattern in, digit and illegal flag out.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       illegal
);

  seg7_dec_t dec;

  // Table lookup through the shared package function.
  always_comb begin
    dec     = seg7_decode_pattern(pattern);
    digit   = dec.digit;
    illegal = dec.illegal;
  end

endmodule

// File: rtl/seg_seq_decoder.sv
// Decodes strobed seven-segment patterns and tracks them against an expected
// digit sequence, pulsing seq_match on each complete occurrence.
module seg_seq_decoder
  import seg7_pkg::*;
#(
  parameter int                    SEQ_LEN  = 10,
  parameter logic [4*SEQ_LEN-1:0]  EXPECTED = 40'h2021040907
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  input  logic       seg_valid,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       seg_err,
  output logic       seq_match,
  output logic       locked,
  output logic [3:0] pos
);

  localparam logic [3:0] LAST_POS = 4'(SEQ_LEN - 1);

  seq_state_t state, state_nxt;
  logic [3:0] pos_nxt;
  logic [3:0] digit_nxt;
  logic       digit_valid_nxt;
  logic       seg_err_nxt;
  logic       seq_match_nxt;
  logic       locked_nxt;

  logic [3:0] dec_digit;
  logic       dec_illegal;
  logic       digit_hit;
  logic       first_hit;
  logic       at_last;

  logic [3:0] exp_tab [16];

  // Expected digits unpacked so that digit 0 is the most-significant nibble;
  // slots beyond SEQ_LEN are never addressed because pos stays below SEQ_LEN.
  for (genvar i = 0; i < 16; i++) begin : g_exp
    if (i < SEQ_LEN) begin : g_used
      assign exp_tab[i] = EXPECTED[4*(SEQ_LEN-1-i) +: 4];
    end else begin : g_unused
      assign exp_tab[i] = 4'h0;
    end
  end

  seg7_decode u_decode (
    .pattern (seg_in),
    .digit   (dec_digit),
    .illegal (dec_illegal)
  );

  assign digit_hit = (dec_digit == exp_tab[pos]);
  assign first_hit = (dec_digit == exp_tab[0]);
  assign at_last   = (pos == LAST_POS);

  // All registers: reset wins over any strobe arriving on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= HUNT;
      pos         <= 4'd0;
      digit       <= 4'd0;
      digit_valid <= 1'b0;
      seg_err     <= 1'b0;
      seq_match   <= 1'b0;
      locked      <= 1'b0;
    end else begin
      state       <= state_nxt;
      pos         <= pos_nxt;
      digit       <= digit_nxt;
      digit_valid <= digit_valid_nxt;
      seg_err     <= seg_err_nxt;
      seq_match   <= seq_match_nxt;
      locked      <= locked_nxt;
    end
  end

  // Next state and position; a mismatch that equals the first digit restarts at pos 1.
  always_comb begin
    state_nxt = state;
    pos_nxt   = pos;
    if (seg_valid) begin
      if (dec_illegal) begin
        state_nxt = HUNT;
        pos_nxt   = 4'd0;
      end else if (state == HUNT) begin
        if (first_hit) begin
          state_nxt = TRACK;
          pos_nxt   = 4'd1;
        end else begin
          state_nxt = HUNT;
          pos_nxt   = 4'd0;
        end
      end else begin
        if (digit_hit) begin
          state_nxt = TRACK;
          pos_nxt   = at_last ? 4'd0 : pos + 4'd1;
        end else if (first_hit) begin
          state_nxt = TRACK;
          pos_nxt   = 4'd1;
        end else begin
          state_nxt = HUNT;
          pos_nxt   = 4'd0;
        end
      end
    end
  end

  // Next output values; pulses default low and the digit/lock status hold between strobes.
  always_comb begin
    digit_nxt       = digit;
    digit_valid_nxt = 1'b0;
    seg_err_nxt     = 1'b0;
    seq_match_nxt   = 1'b0;
    locked_nxt      = locked;
    if (seg_valid) begin
      if (dec_illegal) begin
        seg_err_nxt = 1'b1;
        locked_nxt  = 1'b0;
      end else begin
        digit_nxt       = dec_digit;
        digit_valid_nxt = 1'b1;
        if (state == TRACK) begin
          if (digit_hit && at_last) begin
            seq_match_nxt = 1'b1;
            locked_nxt    = 1'b1;
          end else if (!digit_hit) begin
            locked_nxt = 1'b0;
          end
        end
      end
    end
  end

endmodule
